instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: bus widths and the FSM state encoding.
package instr_fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int WORD_W  = 16;
  localparam int INSTR_W = 2 * WORD_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_HI  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_REQ_LO  = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Word-wide memory bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  addr_t mem_address;
  logic  mem_start;
  logic  mem_rwn;
  word_t mem_data_in;
  word_t mem_data_out;
  logic  mem_ready;

  modport master (
    output mem_address,
    output mem_start,
    output mem_rwn,
    output mem_data_in,
    input  mem_data_out,
    input  mem_ready
  );

  modport slave (
    input  mem_address,
    input  mem_start,
    input  mem_rwn,
    input  mem_data_in,
    output mem_data_out,
    output mem_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a 32-bit instruction as two 16-bit words (pc, pc+1)
// from a handshaked memory, then advances pc by two.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 8'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch,
  input  logic          jump,
  input  addr_t         jump_target,
  output instr_t        instr,
  output logic          instr_valid,
  output addr_t         pc,
  output logic          busy,
  instr_fetch_if.master mem
);

  localparam addr_t PC_STEP_1 = addr_t'(1);
  localparam addr_t PC_STEP_2 = addr_t'(2);

  state_t state;
  state_t state_next;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_ready is only looked at in the wait states.
  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (fetch) state_next = ST_REQ_HI;
      ST_REQ_HI:  state_next = ST_WAIT_HI;
      ST_WAIT_HI: if (mem.mem_ready) state_next = ST_REQ_LO;
      ST_REQ_LO:  state_next = ST_WAIT_LO;
      ST_WAIT_LO: if (mem.mem_ready) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy          = (state != ST_IDLE);
    instr_valid   = (state == ST_DONE);
    mem.mem_start = (state == ST_REQ_HI) || (state == ST_REQ_LO);
  end

  assign mem.mem_rwn     = 1'b1;
  assign mem.mem_data_in = '0;

  // Datapath. mem_address is loaded on entry to each request state so it is
  // stable during the strobe and simply holds afterwards. A simultaneous jump
  // and fetch sends the fetch to jump_target, since pc is only updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      instr           <= '0;
      mem.mem_address <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jump) begin
            pc <= jump_target;
          end
          if (fetch) begin
            mem.mem_address <= jump ? jump_target : pc;
          end
        end
        ST_WAIT_HI: begin
          if (mem.mem_ready) begin
            instr[INSTR_W-1:WORD_W] <= mem.mem_data_out;
            mem.mem_address         <= pc + PC_STEP_1;
          end
        end
        ST_WAIT_LO: begin
          if (mem.mem_ready) begin
            instr[WORD_W-1:0] <= mem.mem_data_out;
            pc                <= pc + PC_STEP_2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected memory
// addresses and instructions; negedge monitors pop and compare.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   fetch = 1'b0;
  logic   jump = 1'b0;
  addr_t  jump_target = '0;
  instr_t instr;
  logic   instr_valid;
  addr_t  pc;
  logic   busy;

  instr_fetch_if mem_bus ();

  instr_fetch #(.RESET_PC(8'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .jump        (jump),
    .jump_target (jump_target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: ready drops when a start is captured and returns
  // addr[1:0]+1 edges later together with the data word.
  function automatic word_t mem_word(input addr_t a);
    case (a)
      8'd0:    return 16'hA140;
      8'd1:    return 16'h21FF;
      8'd18:   return 16'h214A;
      8'd19:   return 16'h6000;
      8'd255:  return 16'h1234;
      default: return {8'hC0, a};
    endcase
  endfunction

  int    lat_cnt = 0;
  addr_t lat_addr = '0;

  initial begin
    mem_bus.mem_ready    = 1'b1;
    mem_bus.mem_data_out = 16'hDEAD;
  end

  always @(posedge clk) begin
    if (lat_cnt > 0) begin
      if (lat_cnt == 1) begin
        mem_bus.mem_ready    <= 1'b1;
        mem_bus.mem_data_out <= mem_word(lat_addr);
      end
      lat_cnt <= lat_cnt - 1;
    end
    if (mem_bus.mem_start) begin
      mem_bus.mem_ready    <= 1'b0;
      mem_bus.mem_data_out <= 16'hDEAD;
      lat_addr             <= mem_bus.mem_address;
      lat_cnt              <= int'(mem_bus.mem_address[1:0]) + 1;
    end
  end

  // Scoreboard
  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_exp_t;

  fetch_exp_t exp_fetch_q[$];
  addr_t      exp_addr_q[$];
  int         valid_cnt = 0;
  int         start_cnt = 0;

  always @(negedge clk) begin
    check("mem_rwn", 32'(mem_bus.mem_rwn), 32'd1);
    check("mem_data_in", 32'(mem_bus.mem_data_in), 32'd0);
    if (mem_bus.mem_start) begin
      start_cnt++;
      check("start_while_mem_busy", 32'(mem_bus.mem_ready), 32'd1);
      check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        check("mem_address", 32'(mem_bus.mem_address), 32'(exp_addr_q.pop_front()));
      end
    end
    if (instr_valid) begin
      valid_cnt++;
      check("fetch_expected", 32'(exp_fetch_q.size() != 0), 32'd1);
      if (exp_fetch_q.size() != 0) begin
        fetch_exp_t e;
        e = exp_fetch_q.pop_front();
        check("instr", instr, e.instr);
        check("pc_at_valid", 32'(pc), 32'(e.pc));
      end
    end
  end

  task automatic drive_cycle(input logic f, input logic j, input addr_t t);
    @(negedge clk);
    fetch = f;
    jump = j;
    jump_target = t;
    @(negedge clk);
    fetch = 1'b0;
    jump = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !mem_bus.mem_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int edges;
    int v0, s0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_mem_start", 32'(mem_bus.mem_start), 32'd0);
    check("rst_mem_address", 32'(mem_bus.mem_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Plain fetch from pc 0, with latency measured in edges
    exp_addr_q.push_back(8'd0);
    exp_addr_q.push_back(8'd1);
    exp_fetch_q.push_back('{instr: 32'hA14021FF, pc: 8'd2});
    drive_cycle(1'b1, 1'b0, 8'd0);
    edges = 0;
    while (!instr_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check("fetch_latency_edges", 32'(edges), 32'd7);
    wait_idle();
    check("s1_pc", 32'(pc), 32'd2);

    // Jump and fetch together
    exp_addr_q.push_back(8'd18);
    exp_addr_q.push_back(8'd19);
    exp_fetch_q.push_back('{instr: 32'h214A6000, pc: 8'd20});
    drive_cycle(1'b1, 1'b1, 8'd18);
    wait_idle();
    check("s2_pc", 32'(pc), 32'd20);

    // Jump alone to 255, then fetch across the wrap
    drive_cycle(1'b0, 1'b1, 8'd255);
    check("s3_jump_pc", 32'(pc), 32'd255);
    check("s3_jump_busy", 32'(busy), 32'd0);
    exp_addr_q.push_back(8'd255);
    exp_addr_q.push_back(8'd0);
    exp_fetch_q.push_back('{instr: 32'h1234A140, pc: 8'd1});
    drive_cycle(1'b1, 1'b0, 8'd0);
    wait_idle();
    check("s3_pc", 32'(pc), 32'd1);

    // fetch and jump held while busy are ignored
    v0 = valid_cnt;
    s0 = start_cnt;
    exp_addr_q.push_back(8'd1);
    exp_addr_q.push_back(8'd2);
    exp_fetch_q.push_back('{instr: 32'h21FFC002, pc: 8'd3});
    @(negedge clk);
    fetch = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) break;
      fetch = busy && !instr_valid;
      jump = busy && !instr_valid;
      jump_target = 8'd99;
    end
    fetch = 1'b0;
    jump = 1'b0;
    wait_idle();
    check("s4_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check("s4_start_pulses", 32'(start_cnt - s0), 32'd2);
    check("s4_pc", 32'(pc), 32'd3);

    // Reset while waiting for the low word
    v0 = valid_cnt;
    s0 = start_cnt;
    exp_addr_q.push_back(8'd6);
    exp_addr_q.push_back(8'd7);
    @(negedge clk);
    fetch = 1'b1;
    jump = 1'b1;
    jump_target = 8'd6;
    @(negedge clk);
    fetch = 1'b0;
    jump = 1'b0;
    n = 0;
    while (start_cnt < s0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s5_reached_req_lo", 32'(start_cnt - s0), 32'd2);
    @(negedge clk);
    check("s5_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_pc", 32'(pc), 32'd0);
    check("s5_instr", instr, 32'd0);
    wait_idle();
    repeat (4) @(negedge clk);
    check("s5_instr_after_ready", instr, 32'd0);
    check("s5_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("s5_pc_after_ready", 32'(pc), 32'd0);

    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("fetch_queue_drained", 32'(exp_fetch_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
